// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: shared widths, ALU opcodes and bus payload types for
// the shared-ALU arbiter slice.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority, requester 0 wins).
package alu_share_arb_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned TAGW         = 4;
    localparam int unsigned SHAMTW       = 5;
    localparam int unsigned ALUCTRLW     = 4;
    localparam int unsigned ALUCTRL1W    = 3;
    localparam int unsigned ALU_ARB_NREQ = 2;

    // ALU operation select
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_MOVEA = 4'd0;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_ADD   = 4'd1;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_ADDU  = 4'd2;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_SUB   = 4'd3;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_SUBU  = 4'd4;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_AND   = 4'd5;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_OR    = 4'd6;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_XOR   = 4'd7;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_NOR   = 4'd8;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_SLL   = 4'd9;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_SRL   = 4'd10;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_SRA   = 4'd11;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_SLT   = 4'd12;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_SLTU  = 4'd13;
    localparam logic [ALUCTRLW-1:0] ALU_CTRL_LUI   = 4'd14;

    // Branch compare select (0 = none)
    localparam logic [ALUCTRL1W-1:0] ALU_BNONE = 3'd0;
    localparam logic [ALUCTRL1W-1:0] ALU_BEQ   = 3'd1;
    localparam logic [ALUCTRL1W-1:0] ALU_BNE   = 3'd2;
    localparam logic [ALUCTRL1W-1:0] ALU_BLT   = 3'd3;
    localparam logic [ALUCTRL1W-1:0] ALU_BGE   = 3'd4;
    localparam logic [ALUCTRL1W-1:0] ALU_BLTU  = 3'd5;
    localparam logic [ALUCTRL1W-1:0] ALU_BGEU  = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]      a;
        logic [XLEN-1:0]      b;
        logic [SHAMTW-1:0]    shamt;
        logic [ALUCTRLW-1:0]  aluctrl;
        logic [ALUCTRL1W-1:0] aluctrl1;
        logic [TAGW-1:0]      tag;
    } alu_req_t;

    typedef struct packed {
        logic            id;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] aluout;
        logic            zero;
        logic            overflow;
    } alu_rsp_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response bus between the two requesters plus the
// result consumer (master side) and the arbiter (slave side).
//   req_valid/req_ready : per-requester handshake
//   req0/req1           : request payloads (operands, ops, tag)
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/tag/aluout/zero/overflow : result fields
interface alu_share_arb_if;
    import alu_share_arb_pkg::*;

    logic [ALU_ARB_NREQ-1:0] req_valid;
    logic [ALU_ARB_NREQ-1:0] req_ready;
    alu_req_t                req0;
    alu_req_t                req1;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_id;
    logic [TAGW-1:0]         rsp_tag;
    logic [XLEN-1:0]         rsp_aluout;
    logic                    rsp_zero;
    logic                    rsp_overflow;

    modport master (
        output req_valid, req0, req1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_aluout, rsp_zero, rsp_overflow
    );

    modport slave (
        input  req_valid, req0, req1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_aluout, rsp_zero, rsp_overflow
    );

endinterface

// File: rtl/alu_share_arb_alu.sv
// alu: combinational core ALU shared by the arbiter.
//   a, b, shamt, aluctrl, aluctrl1 in; aluout, zero, overflow out.
//   aluctrl1 != 0 selects a branch compare and aluout becomes 0/1.
module alu
    import alu_share_arb_pkg::*;
(
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    input  logic [SHAMTW-1:0]    shamt,
    input  logic [ALUCTRLW-1:0]  aluctrl,
    input  logic [ALUCTRL1W-1:0] aluctrl1,
    output logic [XLEN-1:0]      aluout,
    output logic                 zero,
    output logic                 overflow
);

    logic [XLEN-1:0] sum_c;
    logic [XLEN-1:0] diff_c;
    logic            slt_c;
    logic            sltu_c;
    logic            cmp_c;

    assign sum_c  = a + b;
    assign diff_c = a - b;
    assign slt_c  = $signed(a) < $signed(b);
    assign sltu_c = a < b;

    // Branch compare outcome
    always_comb begin
        cmp_c = 1'b0;
        case (aluctrl1)
            ALU_BEQ:  cmp_c = (a == b);
            ALU_BNE:  cmp_c = (a != b);
            ALU_BLT:  cmp_c = slt_c;
            ALU_BGE:  cmp_c = ~slt_c;
            ALU_BLTU: cmp_c = sltu_c;
            ALU_BGEU: cmp_c = ~sltu_c;
            default:  cmp_c = 1'b0;
        endcase
    end

    // Arithmetic/logic result; signed overflow only for ADD/SUB
    always_comb begin
        aluout   = '0;
        overflow = 1'b0;
        case (aluctrl)
            ALU_CTRL_MOVEA: aluout = a;
            ALU_CTRL_ADD: begin
                aluout   = sum_c;
                overflow = (a[XLEN-1] == b[XLEN-1]) && (sum_c[XLEN-1] != a[XLEN-1]);
            end
            ALU_CTRL_ADDU:  aluout = sum_c;
            ALU_CTRL_SUB: begin
                aluout   = diff_c;
                overflow = (a[XLEN-1] != b[XLEN-1]) && (diff_c[XLEN-1] != a[XLEN-1]);
            end
            ALU_CTRL_SUBU:  aluout = diff_c;
            ALU_CTRL_AND:   aluout = a & b;
            ALU_CTRL_OR:    aluout = a | b;
            ALU_CTRL_XOR:   aluout = a ^ b;
            ALU_CTRL_NOR:   aluout = ~(a | b);
            ALU_CTRL_SLL:   aluout = a << shamt;
            ALU_CTRL_SRL:   aluout = a >> shamt;
            ALU_CTRL_SRA:   aluout = XLEN'($signed(a) >>> shamt);
            ALU_CTRL_SLT:   aluout = XLEN'(slt_c);
            ALU_CTRL_SLTU:  aluout = XLEN'(sltu_c);
            ALU_CTRL_LUI:   aluout = b;
            default:        aluout = '0;
        endcase
        if (aluctrl1 != ALU_BNONE) begin
            aluout   = XLEN'(cmp_c);
            overflow = 1'b0;
        end
    end

    assign zero = (aluout == '0);

endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// rr_arb2: two-way grant logic producing a one-hot (or zero) grant.
//   req_valid_i : per-requester valid
//   prio_i      : requester favoured on contention (round-robin build only)
//   grant_o     : one-hot grant
// Macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins, prio_i is removed.
module rr_arb2
    import alu_share_arb_pkg::*;
(
    input  logic [ALU_ARB_NREQ-1:0] req_valid_i,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic                    prio_i,
`endif
    output logic [ALU_ARB_NREQ-1:0] grant_o
);

    always_comb begin
        grant_o = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (req_valid_i[0]) begin
            grant_o = 2'b01;
        end else if (req_valid_i[1]) begin
            grant_o = 2'b10;
        end
`else
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = prio_i ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
`endif
    end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: time-shares one ALU between two requesters and buffers the
// result in a one-entry valid/ready slot.
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_share_arb_if.slave (requests in, result out)
// Macro ALU_ARB_FIXED_PRIO_EN: fixed priority to requester 0, no prio state.
module alu_share_arb
    import alu_share_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    alu_share_arb_if.slave       bus
);

    slot_state_e             state_q, state_d;
    alu_rsp_t                rsp_q, rsp_d;
    logic [ALU_ARB_NREQ-1:0] grant_c;
    logic                    can_accept_c;
    logic                    accept_c;
    logic                    sel_c;
    alu_req_t                req_c;
    logic [XLEN-1:0]         aluout_c;
    logic                    zero_c;
    logic                    overflow_c;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                    prio_q, prio_d;
`endif

    rr_arb2 u_rr_arb2 (
        .req_valid_i (bus.req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .prio_i      (prio_q),
`endif
        .grant_o     (grant_c)
    );

    // Slot can take a new result when empty or draining this cycle
    assign can_accept_c  = (state_q == SLOT_EMPTY) | bus.rsp_ready;
    assign bus.req_ready = reset ? 2'b00 : (grant_c & {ALU_ARB_NREQ{can_accept_c}});
    assign accept_c      = |bus.req_ready;

    // Mux parks on requester 0 when nobody is granted
    assign sel_c = grant_c[1];
    assign req_c = sel_c ? bus.req1 : bus.req0;

    alu u_alu (
        .a        (req_c.a),
        .b        (req_c.b),
        .shamt    (req_c.shamt),
        .aluctrl  (req_c.aluctrl),
        .aluctrl1 (req_c.aluctrl1),
        .aluout   (aluout_c),
        .zero     (zero_c),
        .overflow (overflow_c)
    );

    // Slot next-state and capture
    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        prio_d  = prio_q;
`endif
        if (accept_c) begin
            state_d        = SLOT_FULL;
            rsp_d.id       = sel_c;
            rsp_d.tag      = req_c.tag;
            rsp_d.aluout   = aluout_c;
            rsp_d.zero     = zero_c;
            rsp_d.overflow = overflow_c;
`ifndef ALU_ARB_FIXED_PRIO_EN
            prio_d         = ~sel_c;
`endif
        end else if ((state_q == SLOT_FULL) && bus.rsp_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            rsp_q   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            prio_q  <= prio_d;
`endif
        end
    end

    assign bus.rsp_valid    = (state_q == SLOT_FULL);
    assign bus.rsp_id       = rsp_q.id;
    assign bus.rsp_tag      = rsp_q.tag;
    assign bus.rsp_aluout   = rsp_q.aluout;
    assign bus.rsp_zero     = rsp_q.zero;
    assign bus.rsp_overflow = rsp_q.overflow;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed stimulus for alu_share_arb with a cycle-level
// behavioural model compared every cycle, plus literal expectations.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_share_arb_if bus ();

    alu_share_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic alu_req_t mk(input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sh, input logic [3:0] op,
                                    input logic [2:0] op1, input logic [3:0] tag);
        alu_req_t r;
        r.a = a; r.b = b; r.shamt = sh; r.aluctrl = op; r.aluctrl1 = op1; r.tag = tag;
        return r;
    endfunction

    // Reference ALU from plain 64-bit integer arithmetic
    function automatic alu_rsp_t ref_alu(input alu_req_t r, input logic id);
        alu_rsp_t o;
        longint sa, sb, ua, ub, s;
        logic [31:0] res;
        logic ov;
        sa = longint'($signed(r.a)); sb = longint'($signed(r.b));
        ua = longint'(r.a);          ub = longint'(r.b);
        ov = 1'b0;
        res = 32'd0;
        case (r.aluctrl)
            ALU_CTRL_MOVEA: res = r.a;
            ALU_CTRL_ADD:  begin s = sa + sb; res = 32'(s); ov = (s > SMAX) || (s < SMIN); end
            ALU_CTRL_ADDU: res = 32'(ua + ub);
            ALU_CTRL_SUB:  begin s = sa - sb; res = 32'(s); ov = (s > SMAX) || (s < SMIN); end
            ALU_CTRL_SUBU: res = 32'(ua - ub);
            ALU_CTRL_AND:  res = r.a & r.b;
            ALU_CTRL_OR:   res = r.a | r.b;
            ALU_CTRL_XOR:  res = r.a ^ r.b;
            ALU_CTRL_NOR:  res = ~(r.a | r.b);
            ALU_CTRL_SLL:  res = 32'(ua << r.shamt);
            ALU_CTRL_SRL:  res = 32'(ua >> r.shamt);
            ALU_CTRL_SRA:  res = 32'(sa >>> r.shamt);
            ALU_CTRL_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
            ALU_CTRL_SLTU: res = (ua < ub) ? 32'd1 : 32'd0;
            ALU_CTRL_LUI:  res = r.b;
            default:       res = 32'd0;
        endcase
        if (r.aluctrl1 != 3'd0) begin
            ov = 1'b0;
            case (r.aluctrl1)
                ALU_BEQ:  res = (ua == ub) ? 32'd1 : 32'd0;
                ALU_BNE:  res = (ua != ub) ? 32'd1 : 32'd0;
                ALU_BLT:  res = (sa < sb)  ? 32'd1 : 32'd0;
                ALU_BGE:  res = (sa >= sb) ? 32'd1 : 32'd0;
                ALU_BLTU: res = (ua < ub)  ? 32'd1 : 32'd0;
                ALU_BGEU: res = (ua >= ub) ? 32'd1 : 32'd0;
                default:  res = 32'd0;
            endcase
        end
        o.id = id; o.tag = r.tag; o.aluout = res; o.zero = (res == 32'd0); o.overflow = ov;
        return o;
    endfunction

    // Model state: slot contents, favoured requester, check enable
    logic     m_valid;
    alu_rsp_t m_rsp;
    logic     m_prio;
    bit       chk_en = 1'b0;
    logic [1:0] m_grant, m_ready, prev_v, prev_acc;
    alu_req_t   prev_r0, prev_r1;

    always @(negedge clk) begin
        if (bus.req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            m_grant = 2'b01;
`else
            m_grant = m_prio ? 2'b10 : 2'b01;
`endif
        end else begin
            m_grant = bus.req_valid;
        end
        m_ready = (reset || !(!m_valid || bus.rsp_ready)) ? 2'b00 : m_grant;
        if (chk_en) begin
            chk("req_ready",    64'(bus.req_ready),    64'(m_ready));
            chk("rsp_valid",    64'(bus.rsp_valid),    64'(m_valid));
            chk("rsp_id",       64'(bus.rsp_id),       64'(m_rsp.id));
            chk("rsp_tag",      64'(bus.rsp_tag),      64'(m_rsp.tag));
            chk("rsp_aluout",   64'(bus.rsp_aluout),   64'(m_rsp.aluout));
            chk("rsp_zero",     64'(bus.rsp_zero),     64'(m_rsp.zero));
            chk("rsp_overflow", 64'(bus.rsp_overflow), 64'(m_rsp.overflow));
            // Requester stability rule on the bench's own stimulus
            if (prev_v[0] && !prev_acc[0])
                assert (bus.req_valid[0] && bus.req0 == prev_r0)
                    else $error("requester 0 changed before acceptance");
            if (prev_v[1] && !prev_acc[1])
                assert (bus.req_valid[1] && bus.req1 == prev_r1)
                    else $error("requester 1 changed before acceptance");
        end
        prev_v   = bus.req_valid;
        prev_acc = bus.req_valid & bus.req_ready;
        prev_r0  = bus.req0;
        prev_r1  = bus.req1;
        if (reset) begin
            m_valid = 1'b0;
            m_rsp   = '0;
            m_prio  = 1'b0;
            chk_en  = 1'b1;
        end else if (m_ready != 2'b00) begin
            m_rsp   = ref_alu(m_ready[1] ? bus.req1 : bus.req0, m_ready[1]);
            m_valid = 1'b1;
            m_prio  = ~m_ready[1];
        end else if (m_valid && bus.rsp_ready) begin
            m_valid = 1'b0;
        end
    end

    task automatic set_req(input int i, input alu_req_t r);
        if (i == 0) bus.req0 = r; else bus.req1 = r;
        bus.req_valid[i] = 1'b1;
    endtask

    // Hold valid requests until accepted, bounded
    task automatic drain();
        logic [1:0] acc;
        int n = 0;
        while (bus.req_valid != 2'b00 && n < 20) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            bus.req_valid = bus.req_valid & ~acc;
            n++;
        end
        if (bus.req_valid != 2'b00) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: req_valid=%b still pending, required 00", bus.req_valid);
            bus.req_valid = 2'b00;
        end
    endtask

    task automatic issue(input int i, input alu_req_t r, input logic [31:0] eo,
                         input logic ez, input logic eov, input string nm);
        @(posedge clk);
        #1;
        set_req(i, r);
        drain();
        @(negedge clk);
        chk({nm, "_valid"}, 64'(bus.rsp_valid),    64'd1);
        chk({nm, "_id"},    64'(bus.rsp_id),       64'(i));
        chk({nm, "_tag"},   64'(bus.rsp_tag),      64'(r.tag));
        chk({nm, "_out"},   64'(bus.rsp_aluout),   64'(eo));
        chk({nm, "_zero"},  64'(bus.rsp_zero),     64'(ez));
        chk({nm, "_ovf"},   64'(bus.rsp_overflow), 64'(eov));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [3:0] id_seq;
    logic [3:0] exp_seq;

    initial begin
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        bus.req0      = '0;
        bus.req1      = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Idle after reset
        @(negedge clk);
        chk("idle_valid",  64'(bus.rsp_valid),    64'd0);
        chk("idle_out",    64'(bus.rsp_aluout),   64'd0);
        chk("idle_tag",    64'(bus.rsp_tag),      64'd0);
        chk("idle_id",     64'(bus.rsp_id),       64'd0);
        chk("idle_zero",   64'(bus.rsp_zero),     64'd0);
        chk("idle_ovf",    64'(bus.rsp_overflow), 64'd0);
        chk("idle_ready",  64'(bus.req_ready),    64'd0);

        // Single add
        issue(0, mk(32'd5, 32'd7, 5'd0, ALU_CTRL_ADD, ALU_BNONE, 4'd3), 32'd12, 1'b0, 1'b0, "add");

        // Contention from a fresh reset
        do_reset();
        bus.req0      = mk(32'd10, 32'd10, 5'd0, ALU_CTRL_SUB, ALU_BNONE, 4'd1);
        bus.req1      = mk(32'hF0, 32'h0F, 5'd0, ALU_CTRL_XOR, ALU_BNONE, 4'd2);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            id_seq[3-k] = bus.rsp_id;
            chk("cont_out",  64'(bus.rsp_aluout), bus.rsp_id ? 64'hFF : 64'h0);
            chk("cont_zero", 64'(bus.rsp_zero),   bus.rsp_id ? 64'd0 : 64'd1);
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_seq = 4'b0000;
`else
        exp_seq = 4'b0101;
`endif
        chk("cont_id_seq", 64'(id_seq), 64'(exp_seq));
        @(posedge clk);
        #1;
        drain();

        // Backpressure: empty the slot, then hold a result
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        set_req(0, mk(32'd1, 32'd2, 5'd0, ALU_CTRL_ADD, ALU_BNONE, 4'd4));
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        set_req(1, mk(32'd3, 32'd4, 5'd0, ALU_CTRL_ADD, ALU_BNONE, 4'd5));
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", 64'(bus.req_ready),  64'd0);
            chk("bp_valid", 64'(bus.rsp_valid),  64'd1);
            chk("bp_out",   64'(bus.rsp_aluout), 64'd3);
            chk("bp_tag",   64'(bus.rsp_tag),    64'd4);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", 64'(bus.req_ready), 64'b10);
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b0;
        @(negedge clk);
        chk("bp_id",  64'(bus.rsp_id),     64'd1);
        chk("bp_out2", 64'(bus.rsp_aluout), 64'd7);
        chk("bp_tag2", 64'(bus.rsp_tag),    64'd5);

        // Branch compares
        issue(1, mk(32'hFFFF_FFFF, 32'd1, 5'd0, ALU_CTRL_SUB, ALU_BLTU, 4'd6), 32'd0, 1'b1, 1'b0, "bltu");
        issue(1, mk(32'hFFFF_FFFF, 32'd1, 5'd0, ALU_CTRL_SUB, ALU_BLT,  4'd7), 32'd1, 1'b0, 1'b0, "blt");

        // Overflow, held, then reset
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        issue(0, mk(32'h7FFF_FFFF, 32'd1, 5'd0, ALU_CTRL_ADD, ALU_BNONE, 4'd8),
              32'h8000_0000, 1'b0, 1'b1, "ovf");
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ovf_held", 64'(bus.rsp_valid), 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req0      = mk(32'd2, 32'd2, 5'd0, ALU_CTRL_ADD, ALU_BNONE, 4'd9);
        bus.req1      = mk(32'd3, 32'd3, 5'd0, ALU_CTRL_ADD, ALU_BNONE, 4'd10);
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_first_id",  64'(bus.rsp_id),     64'd0);
        chk("rst_first_out", 64'(bus.rsp_aluout), 64'd4);
        @(posedge clk);
        #1;
        drain();

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
